// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the write port of one fifo between NUM_REQ producers. Round-robin
//   arbitration in IDLE (one cycle), then the winner owns the port for a burst
//   of up to MAX_BURST accepted beats. Bursts end early on REQ_LAST or when the
//   owner drops REQ_VALID. FIFO_FULL stalls the burst without releasing it.
//
// Ports
//   CLK           clock, rising edge
//   RESET         synchronous reset, active-high
//   REQ_VALID     per-requester beat available
//   REQ_DATA      per-requester data, requester i at [i*FIFO_WIDTH +: FIFO_WIDTH]
//   REQ_LAST      per-requester last-beat flag
//   REQ_READY     per-requester beat accepted this cycle (at most one bit high)
//   FIFO_WR_CMD   write strobe to fifo
//   FIFO_WR_DATA  write data to fifo (0 when no grant)
//   FIFO_FULL     fifo full flag
//   GRANT_VALID   a requester owns the port
//   GRANT_ID      index of the owning requester
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned FIFO_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]            REQ_LAST,
    output logic [NUM_REQ-1:0]            REQ_READY,
    output logic                          FIFO_WR_CMD,
    output logic [FIFO_WIDTH-1:0]         FIFO_WR_DATA,
    input  logic                          FIFO_FULL,
    output logic                          GRANT_VALID,
    output logic [$clog2(NUM_REQ)-1:0]    GRANT_ID
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e            state_q;
    logic [ID_W-1:0]   grant_id_q;
    logic [ID_W-1:0]   last_grant_q;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic [ID_W-1:0]   winner_d;

    assign GRANT_VALID = (state_q == GRANT);
    assign GRANT_ID    = grant_id_q;

    // Round-robin pick: first valid requester after the previous winner.
    // Modulo arithmetic keeps this correct for non-power-of-two NUM_REQ.
    always_comb begin
        logic        found;
        int unsigned idx;
        winner_d = last_grant_q;
        found    = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last_grant_q) + k) % NUM_REQ;
            if (!found && REQ_VALID[idx]) begin
                found    = 1'b1;
                winner_d = idx[ID_W-1:0];
            end
        end
    end

    // Datapath is combinational off the registered grant so a beat can be
    // accepted every cycle of the burst.
    always_comb begin
        REQ_READY    = '0;
        FIFO_WR_CMD  = 1'b0;
        FIFO_WR_DATA = '0;
        if (state_q == GRANT) begin
            REQ_READY[grant_id_q] = !FIFO_FULL;
            FIFO_WR_CMD           = REQ_VALID[grant_id_q] & !FIFO_FULL;
            FIFO_WR_DATA          = REQ_DATA[32'(grant_id_q)*FIFO_WIDTH +: FIFO_WIDTH];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            grant_id_q   <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|REQ_VALID) begin
                        grant_id_q   <= winner_d;
                        last_grant_q <= winner_d;
                        beat_cnt_q   <= '0;
                        state_q      <= GRANT;
                    end
                end
                GRANT: begin
                    if (!REQ_VALID[grant_id_q]) begin
                        // Owner withdrew: release without writing.
                        state_q <= IDLE;
                    end else if (FIFO_WR_CMD) begin
                        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
                        if (REQ_LAST[grant_id_q] ||
                            beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                            state_q <= IDLE;
                        end
                    end
                    // FIFO_FULL: hold grant and beat count.
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-requester producer queues drive the DUT,
// expected beats are queued per requester when stimulus is created and popped
// in order whenever the DUT writes the fifo.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int W  = 32;

    logic              CLK = 1'b0;
    logic              RESET;
    logic [NR-1:0]     REQ_VALID;
    logic [NR*W-1:0]   REQ_DATA;
    logic [NR-1:0]     REQ_LAST;
    logic [NR-1:0]     REQ_READY;
    logic              FIFO_WR_CMD;
    logic [W-1:0]      FIFO_WR_DATA;
    logic              FIFO_FULL;
    logic              GRANT_VALID;
    logic [1:0]        GRANT_ID;

    always #5 CLK = ~CLK;

    fifo_wr_arbiter #(
        .NUM_REQ   (NR),
        .FIFO_WIDTH(W),
        .MAX_BURST (4)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .REQ_VALID   (REQ_VALID),
        .REQ_DATA    (REQ_DATA),
        .REQ_LAST    (REQ_LAST),
        .REQ_READY   (REQ_READY),
        .FIFO_WR_CMD (FIFO_WR_CMD),
        .FIFO_WR_DATA(FIFO_WR_DATA),
        .FIFO_FULL   (FIFO_FULL),
        .GRANT_VALID (GRANT_VALID),
        .GRANT_ID    (GRANT_ID)
    );

    typedef struct {
        logic [NR-1:0] en;
        logic          full;
        logic          gv;
        logic [1:0]    gid;
        logic          wr;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic          rst_v;
    logic [NR-1:0] en_v;
    logic          full_v;

    logic [W-1:0]  pq_d [NR][$];
    bit            pq_l [NR][$];
    logic [W-1:0]  exp_q[NR][$];

    logic          s_gv, s_wr;
    logic [1:0]    s_gid;
    logic [NR-1:0] s_ready;
    logic [W-1:0]  s_data;

    vec_t t1[$], t2[$], t4[$];

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic push(input int i, input logic [W-1:0] d, input bit l);
        pq_d[i].push_back(d);
        pq_l[i].push_back(l);
        exp_q[i].push_back(d);
    endtask

    function automatic vec_t mk(input logic [NR-1:0] en, input logic full, input logic gv,
                                input logic [1:0] gid, input logic wr);
        vec_t v;
        v.en = en; v.full = full; v.gv = gv; v.gid = gid; v.wr = wr;
        return v;
    endfunction

    // One clock: drive at negedge, sample after settling, scoreboard the write
    // that the coming posedge commits.
    task automatic cycle();
        int g;
        @(negedge CLK);
        RESET     = rst_v;
        FIFO_FULL = full_v;
        for (int i = 0; i < NR; i++) begin
            if (en_v[i] && pq_d[i].size() > 0) begin
                REQ_VALID[i]          = 1'b1;
                REQ_DATA[i*W +: W]    = pq_d[i][0];
                REQ_LAST[i]           = pq_l[i][0];
            end else begin
                REQ_VALID[i]          = 1'b0;
                REQ_DATA[i*W +: W]    = $urandom;
                REQ_LAST[i]           = 1'($urandom);
            end
        end
        #1;
        s_gv = GRANT_VALID; s_gid = GRANT_ID; s_wr = FIFO_WR_CMD;
        s_ready = REQ_READY; s_data = FIFO_WR_DATA;
        check("ready_onehot", 32'($countones(REQ_READY) <= 1), 1);
        check("wr_while_full", 32'(FIFO_WR_CMD & FIFO_FULL), 0);
        if (FIFO_WR_CMD) begin
            g = int'(GRANT_ID);
            check("wr_handshake", 32'(REQ_READY[g] & REQ_VALID[g]), 1);
            if (exp_q[g].size() == 0) begin
                check("sb_unexpected_write", FIFO_WR_DATA, ~FIFO_WR_DATA);
            end else begin
                check("sb_data", FIFO_WR_DATA, exp_q[g].pop_front());
            end
            if (REQ_READY[g] && REQ_VALID[g]) begin
                void'(pq_d[g].pop_front());
                void'(pq_l[g].pop_front());
            end
        end
    endtask

    task automatic do_reset();
        rst_v = 1'b1; en_v = '0; full_v = 1'b0;
        cycle();
        cycle();
        check("rst_gv",    32'(s_gv),    0);
        check("rst_gid",   32'(s_gid),   0);
        check("rst_wr",    32'(s_wr),    0);
        check("rst_ready", 32'(s_ready), 0);
        check("rst_data",  s_data,       0);
        rst_v = 1'b0;
    endtask

    task automatic drain();
        bit empty;
        en_v = '1; full_v = 1'b0; rst_v = 1'b0;
        for (int k = 0; k < 400; k++) begin
            cycle();
            empty = 1'b1;
            for (int i = 0; i < NR; i++) if (pq_d[i].size() != 0) empty = 1'b0;
            if (empty && !s_gv) break;
        end
        for (int i = 0; i < NR; i++) begin
            check("drain_left", 32'(pq_d[i].size()), 0);
            check("sb_left",    32'(exp_q[i].size()), 0);
        end
    endtask

    task automatic run_tab(input vec_t t[$], input string tag);
        for (int k = 0; k < t.size(); k++) begin
            en_v = t[k].en; full_v = t[k].full;
            cycle();
            check({tag, "_gv"}, 32'(s_gv), 32'(t[k].gv));
            check({tag, "_wr"}, 32'(s_wr), 32'(t[k].wr));
            if (t[k].gv) check({tag, "_gid"}, 32'(s_gid), 32'(t[k].gid));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq;
        RESET = 1'b1; REQ_VALID = '0; REQ_DATA = '0; REQ_LAST = '0; FIFO_FULL = 1'b0;
        rst_v = 1'b1; en_v = '0; full_v = 1'b0;

        // Test 1: req0 alone, 3-beat burst ending on LAST.
        t1.push_back(mk(4'b0001, 0, 0, 0, 0));
        t1.push_back(mk(4'b0001, 0, 1, 0, 1));
        t1.push_back(mk(4'b0001, 0, 1, 0, 1));
        t1.push_back(mk(4'b0001, 0, 1, 0, 1));
        t1.push_back(mk(4'b0001, 0, 0, 0, 0));
        // Test 2: everyone busy, MAX_BURST bursts with one bubble, order 0,1,2,3,0.
        for (int c = 0; c < 26; c++) begin
            if (c % 5 == 0) t2.push_back(mk(4'hF, 0, 0, 0, 0));
            else            t2.push_back(mk(4'hF, 0, 1, 2'(((c - 1) / 5) % 4), 1));
        end
        // Test 4: req2 withdraws after one beat; req3 is next in rotation.
        t4.push_back(mk(4'b0100, 0, 0, 0, 0));
        t4.push_back(mk(4'b0100, 0, 1, 2, 1));
        t4.push_back(mk(4'b1000, 0, 1, 2, 0));
        t4.push_back(mk(4'b1100, 0, 0, 0, 0));
        t4.push_back(mk(4'b1100, 0, 1, 3, 1));
        t4.push_back(mk(4'b1100, 0, 1, 3, 1));
        t4.push_back(mk(4'b1100, 0, 0, 0, 0));
        t4.push_back(mk(4'b1100, 0, 1, 2, 1));

        do_reset();
        push(0, 32'hA0, 0); push(0, 32'hA1, 0); push(0, 32'hA2, 1);
        run_tab(t1, "t1");
        drain();

        do_reset();
        for (int k = 0; k < 8; k++) push(0, 32'h2000_0000 + 32'(k), 0);
        for (int i = 1; i < NR; i++)
            for (int k = 0; k < 4; k++) push(i, 32'h2000_0000 + 32'(i << 8) + 32'(k), 0);
        run_tab(t2, "t2");
        drain();

        // Test 3: FULL stall mid-burst holds the grant and the beat count.
        do_reset();
        for (int k = 0; k < 6; k++) push(1, 32'hF0 + 32'(k), 0);
        en_v = 4'b0010; full_v = 1'b0;
        cycle(); check("t3_idle_gv", 32'(s_gv), 0);
        cycle(); check("t3_b0_wr", 32'(s_wr), 1);
        cycle(); check("t3_b1_wr", 32'(s_wr), 1);
        full_v = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("t3_stall_wr",    32'(s_wr),    0);
            check("t3_stall_ready", 32'(s_ready), 0);
            check("t3_stall_gv",    32'(s_gv),    1);
            check("t3_stall_gid",   32'(s_gid),   1);
        end
        full_v = 1'b0;
        cycle(); check("t3_b2_wr", 32'(s_wr), 1);
        cycle(); check("t3_b3_wr", 32'(s_wr), 1);
        cycle(); check("t3_release_gv", 32'(s_gv), 0);
        drain();

        do_reset();
        push(2, 32'hC0, 0); push(2, 32'hC1, 0); push(2, 32'hC2, 0);
        push(3, 32'hD0, 0); push(3, 32'hD1, 1);
        run_tab(t4, "t4");
        drain();

        // Test 5: reset during req1's second beat; req0 wins after release.
        do_reset();
        for (int k = 0; k < 4; k++) push(1, 32'hB0 + 32'(k), 0);
        en_v = 4'b0010;
        cycle(); check("t5_idle_gv", 32'(s_gv), 0);
        cycle(); check("t5_b0_gid", 32'(s_gid), 1);
        rst_v = 1'b1;
        cycle(); check("t5_b1_wr", 32'(s_wr), 1);
        rst_v = 1'b0;
        push(0, 32'hE0, 0); push(0, 32'hE1, 1);
        en_v = 4'b0011;
        cycle();
        check("t5_post_gv",    32'(s_gv),    0);
        check("t5_post_gid",   32'(s_gid),   0);
        check("t5_post_wr",    32'(s_wr),    0);
        check("t5_post_ready", 32'(s_ready), 0);
        check("t5_post_data",  s_data,       0);
        cycle();
        check("t5_win_gv",  32'(s_gv),  1);
        check("t5_win_gid", 32'(s_gid), 0);
        drain();

        // Test 6: random valid/last/full; invariants and ordering via scoreboard.
        seq = 0;
        for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (pq_d[i].size() < 6 && $urandom_range(0, 1) == 1) begin
                    push(i, {8'(i), 24'(seq)}, ($urandom_range(0, 3) == 0));
                    seq++;
                end
            end
            en_v   = 4'($urandom);
            full_v = ($urandom_range(0, 3) == 0);
            cycle();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
